// File: rtl/asym_pattern_pkg.sv
// Shared types and helpers for the asymmetric multi-segment pattern generator.
package asym_pattern_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_SEG   = 2'd2
  } chan_state_e;

  // Even segment indices drive high, odd ones drive low.
  function automatic logic seg_level(input int unsigned idx);
    return ((idx % 32'd2) == 32'd0);
  endfunction

endpackage

// File: rtl/asym_pattern_chan.sv
// One pattern channel: segment table, start delay, pass counting and a registered
// waveform output. Zero-length segments are skipped without consuming a cycle.
module asym_pattern_chan
  import asym_pattern_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int CNT_W   = 8,
  localparam int SEG_W  = $clog2(NUM_SEG)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_we,
  input  logic             i_is_delay,
  input  logic [SEG_W-1:0] i_seg,
  input  logic [CNT_W-1:0] i_len,
  input  logic [CNT_W-1:0] i_loop_cnt,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_wave,
  output logic             o_busy,
  output logic             o_done
);

  logic [CNT_W-1:0] r_seg_len [NUM_SEG];
  logic [CNT_W-1:0] r_delay;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_loop;
  logic             r_cont;
  logic [SEG_W-1:0] r_idx;
  chan_state_e      r_state;
  logic             r_wave;
  logic             r_busy;
  logic             r_done;

  logic             w_any;
  logic [SEG_W-1:0] w_first;
  logic             w_has_next;
  logic [SEG_W-1:0] w_next;
  logic [SEG_W-1:0] w_tgt;
  logic [CNT_W-1:0] w_tgt_len;
  logic             w_cfg_wr;

  // Locate the first non-zero segment and the next non-zero one after r_idx.
  always_comb begin
    w_any      = 1'b0;
    w_first    = '0;
    w_has_next = 1'b0;
    w_next     = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (r_seg_len[i] != '0) begin
        w_any   = 1'b1;
        w_first = SEG_W'(i);
        if (i > int'(r_idx)) begin
          w_has_next = 1'b1;
          w_next     = SEG_W'(i);
        end else begin
          w_has_next = w_has_next;
        end
      end else begin
        w_any = w_any;
      end
    end
  end

  // Segment to load next: continue within the pass, otherwise restart at the first one.
  always_comb begin
    if ((r_state == ST_SEG) && w_has_next) begin
      w_tgt = w_next;
    end else begin
      w_tgt = w_first;
    end
    w_tgt_len = r_seg_len[w_tgt];
    w_cfg_wr  = i_we && (r_state == ST_IDLE) && !i_start;
  end

  // Channel FSM, counters, table writes and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SEG; i++) begin
        r_seg_len[i] <= '0;
      end
      r_delay <= '0;
      r_cnt   <= '0;
      r_loop  <= '0;
      r_cont  <= 1'b0;
      r_idx   <= '0;
      r_state <= ST_IDLE;
      r_wave  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_cfg_wr) begin
        if (i_is_delay) begin
          r_delay <= i_len;
        end else begin
          r_seg_len[i_seg] <= i_len;
        end
      end
      if (i_stop) begin
        r_state <= ST_IDLE;
        r_wave  <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && w_any) begin
              r_busy <= 1'b1;
              r_loop <= i_loop_cnt;
              r_cont <= (i_loop_cnt == '0);
              if (r_delay != '0) begin
                r_state <= ST_DELAY;
                r_cnt   <= r_delay;
                r_wave  <= 1'b0;
              end else begin
                r_state <= ST_SEG;
                r_idx   <= w_tgt;
                r_cnt   <= w_tgt_len;
                r_wave  <= seg_level(32'(w_tgt));
              end
            end
          end
          ST_DELAY: begin
            if (r_cnt == CNT_W'(1)) begin
              r_state <= ST_SEG;
              r_idx   <= w_tgt;
              r_cnt   <= w_tgt_len;
              r_wave  <= seg_level(32'(w_tgt));
            end else begin
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          ST_SEG: begin
            if (r_cnt != CNT_W'(1)) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else if (w_has_next || r_cont || (r_loop > CNT_W'(1))) begin
              // Pass wrap consumes one loop count unless running continuously.
              if (!w_has_next && !r_cont) begin
                r_loop <= r_loop - CNT_W'(1);
              end
              r_idx  <= w_tgt;
              r_cnt  <= w_tgt_len;
              r_wave <= seg_level(32'(w_tgt));
            end else begin
              r_state <= ST_IDLE;
              r_wave  <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_wave  <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_wave = r_wave;
  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: rtl/asym_pattern_gen.sv
// Multi-channel asymmetric pattern generator: decodes the shared config bus into
// per-channel write enables and instantiates one independent channel per output bit.
module asym_pattern_gen
  import asym_pattern_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int NUM_SEG = 4,
  parameter int CNT_W   = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int SEG_W  = $clog2(NUM_SEG)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_is_delay,
  input  logic [SEG_W-1:0]  cfg_seg,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [CNT_W-1:0]  loop_cnt,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  output logic [NUM_CH-1:0] wave_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  logic [NUM_CH-1:0] w_we;
  logic              w_seg_ok;

  assign w_seg_ok = (32'(cfg_seg) < 32'(NUM_SEG));

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign w_we[c] = cfg_we && (32'(cfg_ch) == 32'(c)) && (cfg_is_delay || w_seg_ok);

    asym_pattern_chan #(
      .NUM_SEG (NUM_SEG),
      .CNT_W   (CNT_W)
    ) u_chan (
      .clock      (clock),
      .reset_n    (reset_n),
      .i_we       (w_we[c]),
      .i_is_delay (cfg_is_delay),
      .i_seg      (cfg_seg),
      .i_len      (cfg_len),
      .i_loop_cnt (loop_cnt),
      .i_start    (start[c]),
      .i_stop     (stop[c]),
      .o_wave     (wave_out[c]),
      .o_busy     (busy[c]),
      .o_done     (done[c])
    );
  end

endmodule

// File: tb/tb_asym_pattern_gen.sv
// Scoreboard bench for asym_pattern_gen: the driver queues hand-written per-cycle
// expectations (H/L running high/low, D done pulse, _ idle) and a monitor checks them.
module tb_asym_pattern_gen;

  logic       clock;
  logic       reset_n;
  logic       cfg_we;
  logic [0:0] cfg_ch;
  logic       cfg_is_delay;
  logic [1:0] cfg_seg;
  logic [7:0] cfg_len;
  logic [7:0] loop_cnt;
  logic [1:0] start;
  logic [1:0] stop;
  logic [1:0] wave_out;
  logic [1:0] busy;
  logic [1:0] done;

  typedef struct {
    logic [1:0] wave;
    logic [1:0] busy;
    logic [1:0] done;
    string      tag;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  e_m;
  string cur_tag;
  int    n_cmp;
  int    n_fail;

  asym_pattern_gen #(.NUM_CH(2), .NUM_SEG(4), .CNT_W(8)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_we       (cfg_we),
    .cfg_ch       (cfg_ch),
    .cfg_is_delay (cfg_is_delay),
    .cfg_seg      (cfg_seg),
    .cfg_len      (cfg_len),
    .loop_cnt     (loop_cnt),
    .start        (start),
    .stop         (stop),
    .wave_out     (wave_out),
    .busy         (busy),
    .done         (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: one expectation per falling edge, whenever one is pending.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      e_m = exp_q.pop_front();
      n_cmp++;
      if (wave_out !== e_m.wave || busy !== e_m.busy || done !== e_m.done) begin
        n_fail++;
        $display("FAIL %s @%0t: wave/busy/done got %b/%b/%b, required %b/%b/%b",
                 e_m.tag, $time, wave_out, busy, done, e_m.wave, e_m.busy, e_m.done);
      end
    end
  end

  function automatic string rep(string c, int n);
    string s;
    s = "";
    for (int i = 0; i < n; i++) s = {s, c};
    return s;
  endfunction

  task automatic push_exp(byte c0, byte c1);
    exp_t e;
    e.tag  = cur_tag;
    e.wave = {c1 == "H", c0 == "H"};
    e.busy = {(c1 == "H") || (c1 == "L"), (c0 == "H") || (c0 == "L")};
    e.done = {c1 == "D", c0 == "D"};
    exp_q.push_back(e);
  endtask

  // One clock edge with the given start/stop; expectation is for the state after it.
  task automatic cyc(logic [1:0] st, logic [1:0] sp, byte c0, byte c1);
    start = st;
    stop  = sp;
    @(posedge clock);
    push_exp(c0, c1);
    #1;
    start  = 2'b00;
    stop   = 2'b00;
    cfg_we = 1'b0;
  endtask

  task automatic play(string s0, string s1);
    for (int i = 0; i < s0.len(); i++) cyc(2'b00, 2'b00, s0[i], s1[i]);
  endtask

  task automatic cfg_set(int ch, logic isd, int seg, int len);
    cfg_we       = 1'b1;
    cfg_ch       = 1'(ch);
    cfg_is_delay = isd;
    cfg_seg      = 2'(seg);
    cfg_len      = 8'(len);
  endtask

  task automatic wr(int ch, logic isd, int seg, int len);
    cfg_set(ch, isd, seg, len);
    cyc(2'b00, 2'b00, "_", "_");
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = 1'b0; cfg_is_delay = 1'b0;
    cfg_seg = 2'd0; cfg_len = 8'd0; loop_cnt = 8'd0; start = 2'b00; stop = 2'b00;

    cur_tag = "reset_state";
    @(posedge clock);
    push_exp("_", "_");
    #1;
    reset_n = 1'b1;

    // Delay 1, segments {10,30,1,1}, continuous, then stop in the 4th high cycle.
    cur_tag = "s1_continuous";
    wr(0, 1'b1, 0, 1);
    wr(0, 1'b0, 0, 10); wr(0, 1'b0, 1, 30); wr(0, 1'b0, 2, 1); wr(0, 1'b0, 3, 1);
    cyc(2'b01, 2'b00, "L", "_");
    play({rep("H", 10), rep("L", 30), "HL", rep("H", 4)}, rep("_", 46));
    cur_tag = "s4_stop_mid_high";
    cyc(2'b00, 2'b01, "_", "_");
    play("___", "___");
    cur_tag = "s4_start_stop_same";
    cyc(2'b01, 2'b01, "_", "_");
    play("__", "__");

    // Write to a busy channel is dropped; after stop it lands.
    cur_tag = "s5_busy_write";
    cyc(2'b01, 2'b00, "L", "_");
    play(rep("H", 5), rep("_", 5));
    cfg_set(0, 1'b0, 0, 2);
    cyc(2'b00, 2'b00, "H", "_");
    play({rep("H", 4), rep("L", 30), "HL", rep("H", 10), "L"}, rep("_", 47));
    cyc(2'b00, 2'b01, "_", "_");
    cur_tag = "s5_idle_write";
    wr(0, 1'b0, 0, 2);
    cyc(2'b01, 2'b00, "L", "_");
    play({"HH", rep("L", 30), "HLHHL"}, rep("_", 37));
    cyc(2'b00, 2'b01, "_", "_");

    // Two passes of {3,2,3,2} with no delay, then a single done pulse.
    cur_tag = "s2_loop2";
    wr(0, 1'b1, 0, 0);
    wr(0, 1'b0, 0, 3); wr(0, 1'b0, 1, 2); wr(0, 1'b0, 2, 3); wr(0, 1'b0, 3, 2);
    loop_cnt = 8'd2;
    cyc(2'b01, 2'b00, "H", "_");
    loop_cnt = 8'd0;
    play({"HHLLHHHLL", "HHHLLHHHLL", "D", "___"}, rep("_", 23));

    // Zero-length skipping; a write coincident with start is dropped.
    cur_tag = "s3_zero_skip";
    wr(0, 1'b0, 0, 5); wr(0, 1'b0, 1, 0); wr(0, 1'b0, 2, 0); wr(0, 1'b0, 3, 3);
    cfg_set(0, 1'b0, 0, 1);
    cyc(2'b01, 2'b00, "H", "_");
    play({"HHHHLLL", "HHHHHLLL", "HH"}, rep("_", 17));
    cyc(2'b00, 2'b01, "_", "_");
    cur_tag = "s3_all_zero_ignored";
    cyc(2'b10, 2'b00, "_", "_");
    play("__", "__");

    // Two channels started 3 cycles apart, then an asynchronous reset mid-run.
    cur_tag = "s6_two_channels";
    wr(0, 1'b0, 0, 2); wr(0, 1'b0, 1, 2); wr(0, 1'b0, 2, 2); wr(0, 1'b0, 3, 2);
    wr(1, 1'b1, 0, 2);
    wr(1, 1'b0, 0, 1); wr(1, 1'b0, 1, 3); wr(1, 1'b0, 2, 1); wr(1, 1'b0, 3, 3);
    cyc(2'b01, 2'b00, "H", "_");
    play("HL", "__");
    cyc(2'b10, 2'b00, "L", "L");
    play("HHLLH", "LHLLL");
    cur_tag = "s6_async_reset";
    @(posedge clock);
    push_exp("_", "_");
    #1;
    reset_n = 1'b0;
    cyc(2'b00, 2'b00, "_", "_");
    reset_n = 1'b1;
    cur_tag = "s6_post_reset_start";
    cyc(2'b11, 2'b00, "_", "_");
    play("__", "__");
    cur_tag = "s6_reprogram";
    wr(0, 1'b0, 0, 2); wr(0, 1'b0, 1, 1);
    cyc(2'b01, 2'b00, "H", "_");
    play("HLHH", "____");
    cyc(2'b00, 2'b01, "_", "_");

    repeat (2) @(negedge clock);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
